// File: rtl/operand_stream_adder.sv
// Serial-in operand adder/subtractor: two WIDTH-bit operands arrive as LANE-bit beats,
// and the (WIDTH+1)-bit result leaves as bytes. Define OSA_OVF_EN to enable signed-overflow.
module operand_stream_adder #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned LANE  = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LANE-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_cin,
   input  logic            in_op,
   output logic [7:0]      out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_ovf
);

   localparam int unsigned NB = WIDTH / LANE;
   localparam int unsigned NO = (WIDTH + 8) / 8;
   localparam int unsigned RW = NO * 8;
   localparam logic [6:0]  BeatLast = 7'(NB - 1);
   localparam logic [3:0]  ByteLast = 4'(NO - 1);

   typedef enum logic [1:0] {StLoadA, StLoadB, StCompute, StSend} state_e;

   state_e           state_q;
   logic [6:0]       beat_cnt_q;
   logic [3:0]       byte_cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [RW-1:0]    r_q;
   logic             op_q;
   logic             cin_q;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [RW-1:0]    r_shift;
   logic [WIDTH-1:0] beat_ext;

   assign b_eff    = op_q ? ~b_q : b_q;
   assign sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q | cin_q)};
   assign beat_ext = WIDTH'(in_data) << (WIDTH - LANE);
   assign r_shift  = r_q >> (8 * byte_cnt_q);

   // Outputs are decoded from state and forced inactive while reset is held.
   assign in_ready  = !rst && (state_q == StLoadA || state_q == StLoadB);
   assign out_valid = !rst && (state_q == StSend);
   assign out_data  = out_valid ? r_shift[7:0] : 8'h00;

`ifdef OSA_OVF_EN
   logic ovf_q;
   assign out_ovf = out_valid && ovf_q;
`else
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLoadA;
         beat_cnt_q <= '0;
         byte_cnt_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         op_q       <= 1'b0;
         cin_q      <= 1'b0;
`ifdef OSA_OVF_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            StLoadA: begin
               if (in_valid) begin
                  if (beat_cnt_q == '0) begin
                     op_q  <= in_op;
                     cin_q <= in_cin;
                  end
                  // Beats arrive LSB first, so shift them in from the top.
                  a_q <= (a_q >> LANE) | beat_ext;
                  if (beat_cnt_q == BeatLast) begin
                     beat_cnt_q <= '0;
                     state_q    <= StLoadB;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 7'd1;
                  end
               end
            end
            StLoadB: begin
               if (in_valid) begin
                  b_q <= (b_q >> LANE) | beat_ext;
                  if (beat_cnt_q == BeatLast) begin
                     beat_cnt_q <= '0;
                     state_q    <= StCompute;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 7'd1;
                  end
               end
            end
            StCompute: begin
               r_q        <= RW'(sum);
               byte_cnt_q <= '0;
`ifdef OSA_OVF_EN
               ovf_q      <= (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
               state_q    <= StSend;
            end
            StSend: begin
               if (out_ready) begin
                  if (byte_cnt_q == ByteLast) begin
                     byte_cnt_q <= '0;
                     state_q    <= StLoadA;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 4'd1;
                  end
               end
            end
            default: state_q <= StLoadA;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_stream_adder.sv
// Directed bench for operand_stream_adder: a 24/6 instance and an 8/4 instance side by side.
module tb_operand_stream_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [5:0] in_data;
   logic       in_valid, in_ready, in_cin, in_op;
   logic [7:0] out_data;
   logic       out_valid, out_ready, out_ovf;

   logic [3:0] s_in_data;
   logic       s_in_valid, s_in_ready, s_in_cin, s_in_op;
   logic [7:0] s_out_data;
   logic       s_out_valid, s_out_ready, s_out_ovf;

   int checks = 0;
   int errors = 0;

`ifdef OSA_OVF_EN
   localparam logic OvfOn = 1'b1;
`else
   localparam logic OvfOn = 1'b0;
`endif

   operand_stream_adder #(.WIDTH(24), .LANE(6)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_cin(in_cin), .in_op(in_op), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ovf(out_ovf)
   );

   operand_stream_adder #(.WIDTH(8), .LANE(4)) dut8 (
      .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_cin(s_in_cin), .in_op(s_in_op), .out_data(s_out_data), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_ovf(s_out_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives 4 A beats then b_beats B beats; op/cin are inverted on every beat that must ignore them.
   task automatic load24(input logic [23:0] a, input logic [23:0] b, input logic op,
                         input logic cin, input int idle_at, input int b_beats);
      for (int i = 0; i < 4 + b_beats; i++) begin
         if (i == idle_at) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_op    = ~op;
            in_cin   = ~cin;
            in_data  = 6'h3f;
         end
         @(negedge clk);
         check("load_ready", in_ready, 1);
         check("load_no_valid", out_valid, 0);
         in_valid = 1'b1;
         in_op    = (i == 0) ? op : ~op;
         in_cin   = (i == 0) ? cin : ~cin;
         in_data  = (i < 4) ? a[i*6 +: 6] : b[(i-4)*6 +: 6];
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (b_beats == 4) begin
         check("compute_ready", in_ready, 0);
         check("compute_valid", out_valid, 0);
      end
   endtask

   task automatic recv24(input logic [31:0] exp, input int stall_at, input logic exp_ovf);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, exp[k*8 +: 8]);
               check("stall_ovf", out_ovf, exp_ovf);
               check("stall_ready", in_ready, 0);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         check("out_valid", out_valid, 1);
         check("out_data", out_data, exp[k*8 +: 8]);
         check("out_ovf", out_ovf, exp_ovf);
         check("send_ready", in_ready, 0);
      end
      @(negedge clk);
      check("done_ready", in_ready, 1);
      check("done_valid", out_valid, 0);
   endtask

   task automatic load8(input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic cin);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("w8_load_ready", s_in_ready, 1);
         s_in_valid = 1'b1;
         s_in_op    = op;
         s_in_cin   = cin;
         s_in_data  = (i < 2) ? a[i*4 +: 4] : b[(i-2)*4 +: 4];
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      check("w8_compute_ready", s_in_ready, 0);
      check("w8_compute_valid", s_out_valid, 0);
   endtask

   task automatic recv8(input logic [15:0] exp);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("w8_out_valid", s_out_valid, 1);
         check("w8_out_data", s_out_data, exp[k*8 +: 8]);
         check("w8_send_ready", s_in_ready, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_data = '0; in_valid = 1'b0; in_cin = 1'b0; in_op = 1'b0; out_ready = 1'b1;
      s_in_data = '0; s_in_valid = 1'b0; s_in_cin = 1'b0; s_in_op = 1'b0; s_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_ovf", out_ovf, 0);
      check("rst_ready_w8", s_in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);

      // Add with carry-out, with an idle cycle inside the A load.
      load24(24'h000001, 24'hFFFFFF, 1'b0, 1'b0, 2, 4);
      recv24(32'h01000000, -1, 1'b0);
      // Subtract: cin must be ignored.
      load24(24'h000005, 24'h000007, 1'b1, 1'b1, -1, 4);
      recv24(32'h00FFFFFE, -1, 1'b0);
      // Signed overflow with backpressure on byte 2.
      load24(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, -1, 4);
      recv24(32'h00800000, 2, OvfOn);

      // Reset after 2 B beats; the partial transaction must vanish.
      load24(24'h123456, 24'h654321, 1'b1, 1'b1, -1, 2);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_ready", in_ready, 1);
      check("after_rst_valid", out_valid, 0);
      load24(24'h000010, 24'h000020, 1'b0, 1'b1, -1, 4);
      recv24(32'h00000031, -1, 1'b0);

      // Narrow instance, back to back.
      load8(8'hFF, 8'h01, 1'b0, 1'b0);
      recv8(16'h0100);
      load8(8'h10, 8'h20, 1'b1, 1'b0);
      recv8(16'h00F0);
      @(negedge clk);
      check("w8_done_ready", s_in_ready, 1);
      check("w8_done_valid", s_out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
